// File: rtl/sparse_expander.sv
// Rebuilds a sparse LANES-wide vector from a dense in-order element stream and its occupancy mask.
// Optional SPARSE_EXPANDER_OVERLAP_EN: accept the next mask in the same cycle as the output handshake.
module sparse_expander #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 8,
  parameter int unsigned BEAT  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [LANES-1:0]      mask,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BEAT*DW-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_mask,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(LANES) + 1;
  localparam int unsigned PW = CW + 1;

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

  state_t              state;
  logic                mask_ready_q;
  logic [CW-1:0]       count;
  logic [PW-1:0]       ptr;
  logic [CW-1:0]       rank     [LANES];
  logic [CW-1:0]       pre_rank [LANES];
  logic [CW-1:0]       pre_cnt;
  logic [LANES*DW-1:0] fill_data;
  logic [PW-1:0]       ptr_next;
  logic                fill_done;
  logic                mask_fire;
  logic                in_fire;
  logic                out_fire;

`ifdef SPARSE_EXPANDER_OVERLAP_EN
  assign mask_ready = mask_ready_q | (out_valid & out_ready);
`else
  assign mask_ready = mask_ready_q;
`endif

  assign mask_fire = mask_valid & mask_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign busy      = (state != IDLE);
  assign ptr_next  = ptr + PW'(BEAT);
  assign fill_done = (ptr_next >= PW'(count));

  // Exclusive prefix popcount of the incoming mask gives each lane its rank.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      pre_rank[l] = acc;
      acc         = acc + CW'(mask[l]);
    end
    pre_cnt = acc;
  end

  // Populated lanes always have rank below count, so surplus elements in a
  // final partial beat never match any lane and are dropped implicitly.
  always_comb begin
    fill_data = out_data;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned j = 0; j < BEAT; j++) begin
        if (out_mask[l] && (PW'(rank[l]) == ptr + PW'(j))) begin
          fill_data[l*DW +: DW] = in_data[j*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mask_ready_q <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_mask     <= '0;
      count        <= '0;
      ptr          <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        rank[l] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            out_data <= fill_data;
            ptr      <= ptr_next;
            if (fill_done) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            mask_ready_q <= 1'b1;
          end
        end
        default: mask_ready_q <= 1'b1;
      endcase

      // A mask load overrides the case above; in OUT this only happens when
      // the overlap path makes mask_ready follow out_ready.
      if (mask_fire) begin
        out_mask     <= mask;
        count        <= pre_cnt;
        out_data     <= '0;
        ptr          <= '0;
        mask_ready_q <= 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
          rank[l] <= pre_rank[l];
        end
        if (pre_cnt != '0) begin
          state     <= FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end else begin
          state     <= OUT;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
